// File: rtl/multi_channel_integrity_scoreboard.sv
// multi_channel_integrity_scoreboard: per-channel magic-packet integrity monitor beside NUM_CH FIFOs
module multi_channel_integrity_scoreboard #(
   parameter int NUM_CH  = 4,
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int CNTWID  = $clog2(DEPTH) + 1,
   parameter int MAX_LAT = 64,
   parameter int LATW    = $clog2(MAX_LAT + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       push,
   input  logic [NUM_CH-1:0]       pop,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH*WIDTH-1:0] flat_data_in,
   input  logic [NUM_CH*WIDTH-1:0] flat_data_out,
   output logic [NUM_CH-1:0]       chk_vld,
   output logic [NUM_CH-1:0]       chk_pass,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       err_mismatch,
   output logic [NUM_CH-1:0]       err_timeout,
   output logic [NUM_CH-1:0]       err_ovf,
   output logic                    prop_signal
);
   typedef enum logic [1:0] {IDLE, TRACK, DONE, TOUT} state_e;
   localparam logic [CNTWID-1:0] FULL     = CNTWID'(DEPTH);
   localparam logic [CNTWID-1:0] ONE      = CNTWID'(1);
   localparam logic [LATW-1:0]   LAT_LAST = LATW'(MAX_LAT - 1);
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_e            state_q, state_d;
      logic [CNTWID-1:0] occ_q, occ_d, ahead_q, ahead_d;
      logic [LATW-1:0]   lat_q, lat_d;
      logic [WIDTH-1:0]  magic_q, magic_d, din, dout;
      logic              mis_q, tout_q, ovf_q, track, cap, ex, lat_max, ovf_hit;
      assign din     = flat_data_in[c*WIDTH +: WIDTH];
      assign dout    = flat_data_out[c*WIDTH +: WIDTH];
      assign track   = state_q == TRACK;
      assign cap     = (state_q == IDLE || state_q == DONE) && start[c] && push[c];
      assign ex      = track && pop[c] && ahead_q == ONE;
      assign lat_max = lat_q == LAT_LAST;
      assign ovf_hit = push[c] && !pop[c] && occ_q == FULL;
      // The magic packet itself counts toward ahead, so it reaches the head when ahead==1.
      always_comb begin
         occ_d   = (push[c] && !pop[c] && occ_q != FULL) ? occ_q + ONE :
                   (pop[c] && !push[c] && occ_q != '0)   ? occ_q - ONE : occ_q;
         ahead_d = cap ? occ_d : (track && pop[c] && ahead_q != '0) ? ahead_q - ONE : ahead_q;
         lat_d   = cap ? '0 : track ? lat_q + LATW'(1) : lat_q;
         magic_d = cap ? din : magic_q;
         state_d = cap ? TRACK : ex ? DONE : (track && lat_max) ? TOUT : state_q;
      end
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            ahead_q <= '0;
            lat_q   <= '0;
            magic_q <= '0;
            mis_q   <= 1'b0;
            tout_q  <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            ahead_q <= ahead_d;
            lat_q   <= lat_d;
            magic_q <= magic_d;
            mis_q   <= mis_q | (ex && dout != magic_q);
            tout_q  <= tout_q | (track && lat_max && !ex);
            ovf_q   <= ovf_q | ovf_hit;
         end
      end
      assign chk_vld[c]      = ex;
      assign chk_pass[c]     = ex && dout == magic_q;
      assign busy[c]         = track;
      assign err_mismatch[c] = mis_q;
      assign err_timeout[c]  = tout_q;
      assign err_ovf[c]      = ovf_q;
   end
   assign prop_signal = ~|(chk_vld & ~chk_pass);
endmodule

// File: doc/multi_channel_integrity_scoreboard.md
Name: multi_channel_integrity_scoreboard

Overview:
- Passive per-channel data-integrity monitor that sits beside NUM_CH FIFOs feeding the arbiter.
- On a per-channel start, it captures one "magic" packet and tracks its position by counting pops ahead of it.
- At exit, it checks the FIFO head value against the captured copy.
- Adds continuous occupancy tracking, re-arming, a latency watchdog, overflow detection and sticky error flags. Intended for formal and simulation benches.

Parameters:
NUM_CH, 4, number of monitored channels
WIDTH, 8, packet width in bits
DEPTH, 8, depth of each monitored FIFO
CNTWID, $clog2(DEPTH)+1, occupancy/position counter width
MAX_LAT, 64, cycles allowed between capture and exit before timeout
LATW, $clog2(MAX_LAT+1), latency counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
push  in  NUM_CH  accepted write per channel (already gated by ~full upstream)
pop  in  NUM_CH  accepted read per channel (arbiter grant)
start  in  NUM_CH  arm request; capture occurs on a cycle with start[c] & push[c]
flat_data_in  in  NUM_CH*WIDTH  write data; channel c at [(c+1)*WIDTH-1:c*WIDTH]
flat_data_out  in  NUM_CH*WIDTH  FIFO head data; same packing
chk_vld  out  NUM_CH  1-cycle pulse: magic packet leaving channel c this cycle
chk_pass  out  NUM_CH  valid with chk_vld: head equals captured packet
busy  out  NUM_CH  channel in TRACK
err_mismatch  out  NUM_CH  sticky: a check failed
err_timeout  out  NUM_CH  sticky: MAX_LAT reached in TRACK
err_ovf  out  NUM_CH  sticky: push seen with occupancy == DEPTH and no pop
prop_signal  out  1  ~|(chk_vld & ~chk_pass), combinational

Behaviour:
- Reset (rst low, asynchronous): all FSMs go to IDLE; occ, ahead, lat and magic are cleared to 0; every output goes to 0 except prop_signal, which is 1.
- Per-channel occupancy occ[c] is updated every cycle in all states:
  - push & ~pop: +1, saturating at DEPTH; a push at DEPTH also sets err_ovf.
  - pop & ~push: -1, saturating at 0.
  - push & pop: unchanged. The overflow check does not apply.
- FSM states per channel: IDLE, TRACK, DONE, TOUT.
- IDLE -> TRACK on start[c] & push[c]:
  - magic[c] <= data_in[c].
  - ahead[c] <= occ_next[c], which includes the magic packet itself.
  - lat[c] <= 0.
- TRACK behaviour:
  - ahead decrements on pop.
  - lat increments each cycle.
  - start is ignored.
- TRACK -> DONE on pop[c] & ahead[c]==1:
  - chk_vld[c]=1 combinationally in that same cycle.
  - chk_pass[c] = (data_out[c] == magic[c]).
  - If the check fails, err_mismatch[c] is set from the next edge.
- TRACK -> TOUT when lat[c]==MAX_LAT-1 and no exit occurs this cycle; err_timeout[c] is set.
  - If the exit and MAX_LAT coincide, the exit wins and goes to DONE.
- Capture and pop in the same cycle: ahead = occ+1-1. Capture into an empty FIFO with a simultaneous pop is not an exit; ahead becomes the occ_next value.
- DONE -> TRACK on a new start[c] & push[c], with capture as from IDLE.
- TOUT is terminal until reset.
- Sticky errors clear only on reset.
- Channels are fully independent; simultaneous exits on several channels each produce their own chk_vld.
- Latency: the check result is same-cycle as the exiting pop; no pipelining.
- Widths: all compares are unsigned; ahead and occ never wrap.

Test Plan:
1. Ch0 is empty. Push 0x11 with start[0]=1, then pop one cycle later with head=0x11 -> chk_vld[0]=1 and chk_pass[0]=1 on the pop cycle; prop_signal=1; busy[0] falls after the edge.
2. Ch1 has 3 packets queued. Start+push 0xA5, then 3 pops -> no chk_vld. The 4th pop with head=0x5A -> chk_vld[1]=1, chk_pass[1]=0, prop_signal=0; err_mismatch[1]=1 from the next cycle and held.
3. MAX_LAT=64. Capture on ch2 with no pops for 64 cycles -> err_timeout[2]=1 on cycle 64. Later start is ignored and chk_vld[2] never asserts.
4. Fill ch3 to 8, then push again without pop -> err_ovf[3]=1 and occ stays 8. Push+pop together at 8 -> no error.
5. Ch0 and ch1 magic packets exit on the same cycle, ch0 matching and ch1 mismatching -> chk_vld=4'b0011, chk_pass=4'b0001, prop_signal=0.
6. Drop rst mid-TRACK on ch0 -> busy, chk_vld and all errors are 0 immediately, independent of clk. After rst rises, re-arm tracks correctly from occ=0.
